// File: rtl/exe_muldiv.sv
// EXE-stage multiply/divide unit: one-cycle 32x32 multiply, 32-iteration
// restoring divide, pipeline stall request and one-cycle done pulse.
module exe_muldiv #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              flush,
  output logic              stall_req,
  output logic              done,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              div_zero
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, MUL, DIV_RUN, FIN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                dz_q, dz_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                done_q, done_d;
  logic                div_zero_q, div_zero_d;

  logic                    is_signed_c;
  logic signed [DATA_W:0]  mul_a_c, mul_b_c;
  logic signed [PROD_W-1:0] prod_c;
  logic [DATA_W:0]         shift_c;
  logic [DATA_W+1:0]       diff_c;

  // Magnitude of an operand when treated as signed; unsigned values pass through.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic sgn);
    return (sgn && x[DATA_W-1]) ? -x : x;
  endfunction

  // Multiply and divide-step datapath, evaluated from the captured operands.
  always_comb begin
    is_signed_c = ~op_q[0];
    mul_a_c = {is_signed_c & a_q[DATA_W-1], a_q};
    mul_b_c = {is_signed_c & b_q[DATA_W-1], b_q};
    prod_c  = PROD_W'(mul_a_c) * PROD_W'(mul_b_c);
    shift_c = {rem_q, quo_q[DATA_W-1]};
    diff_c  = {1'b0, shift_c} - {2'b00, dvs_q};
  end

  // Next-state, operand capture, result formation and stall request.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    dz_d       = dz_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    stall_req  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          stall_req = 1'b1;
          op_d   = op;
          a_d    = src1;
          b_d    = src2;
          cnt_d  = '0;
          rem_d  = '0;
          quo_d  = mag(src1, ~op[0]);
          dvs_d  = mag(src2, ~op[0]);
          qneg_d = ~op[0] & (src1[DATA_W-1] ^ src2[DATA_W-1]);
          rneg_d = ~op[0] & src1[DATA_W-1];
          dz_d   = op[1] && (src2 == '0);
          // Divide-by-zero uses the one-cycle result slot so it completes like a multiply.
          state_d = (op[1] && (src2 != '0)) ? DIV_RUN : MUL;
        end
      end
      MUL: begin
        stall_req = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else begin
          state_d = FIN;
          done_d  = 1'b1;
          if (dz_q) begin
            hi_d       = a_q;
            lo_d       = '1;
            div_zero_d = 1'b1;
          end else begin
            hi_d = prod_c[PROD_W-1:DATA_W];
            lo_d = prod_c[DATA_W-1:0];
          end
        end
      end
      DIV_RUN: begin
        stall_req = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_CNT) begin
          // All quotient bits are in; apply the result signs.
          hi_d    = rneg_q ? -rem_q : rem_q;
          lo_d    = qneg_q ? -quo_q : quo_q;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          rem_d = diff_c[DATA_W+1] ? shift_c[DATA_W-1:0] : diff_c[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], ~diff_c[DATA_W+1]};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with asynchronous reset.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst_n) begin
    if (cpu_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      dz_q       <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      dz_q       <= dz_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign done     = done_q;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv: results, latency, stall, flush and reset.
module tb_exe_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        stall_req, done, div_zero;
  logic [31:0] hi_o, lo_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  exe_muldiv #(.DATA_W(32)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst),
    .start       (start),
    .op          (op),
    .src1        (src1),
    .src2        (src2),
    .flush       (flush),
    .stall_req   (stall_req),
    .done        (done),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .div_zero    (div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request in the current cycle (called just after a negedge).
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src1  = a;
    src2  = b;
    #1 check("stall_accept", 32'(stall_req), 32'd1);
  endtask

  // Follow the operation cycle by cycle until the expected done cycle.
  task automatic wait_result(input int lat, input logic [31:0] ehi, input logic [31:0] elo,
                             input logic edz);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (k < lat) begin
        check("busy_done", 32'(done), 32'd0);
        check("busy_stall", 32'(stall_req), 32'd1);
      end else begin
        check("done", 32'(done), 32'd1);
        check("hi", hi_o, ehi);
        check("lo", lo_o, elo);
        check("div_zero", 32'(div_zero), 32'(edz));
        check("fin_stall", 32'(stall_req), 32'd0);
        exp_hi = ehi;
        exp_lo = elo;
      end
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    #1;
    check("idle_done", 32'(done), 32'd0);
    check("idle_dz", 32'(div_zero), 32'd0);
    check("idle_stall", 32'(stall_req), 32'd0);
    check("hold_hi", hi_o, exp_hi);
    check("hold_lo", lo_o, exp_lo);
  endtask

  // Back-to-back: the request goes out in the cycle right after the previous done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edz);
    idle_check();
    launch(o, a, b);
    wait_result(lat, ehi, elo, edz);
  endtask

  initial begin
    logic saw_done;
    #3;
    check("rst_hi", hi_o, 32'h0);
    check("rst_lo", lo_o, 32'h0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);

    // First request on the first edge after reset release.
    @(negedge clk);
    rst = 1'b0;
    launch(OP_MULT, 32'hFFFFFFFE, 32'h00000003);
    wait_result(2, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);

    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    do_op(OP_MULT,  32'h80000000, 32'h80000000, 2, 32'h40000000, 32'h00000000, 1'b0);
    do_op(OP_MULTU, 32'h80000000, 32'h00000002, 2, 32'h00000001, 32'h00000000, 1'b0);
    do_op(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    do_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000, 1'b0);
    do_op(OP_DIV,   32'h00000007, 32'hFFFFFFFE, 34, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    do_op(OP_DIVU,  32'd100,      32'd7,        34, 32'd2,        32'd14,       1'b0);
    do_op(OP_DIVU,  32'hFFFFFFFF, 32'd10,       34, 32'd5,        32'h19999999, 1'b0);
    do_op(OP_DIVU,  32'd100,      32'd0,        2,  32'd100,      32'hFFFFFFFF, 1'b1);
    do_op(OP_DIV,   32'hFFFFFFFB, 32'd0,        2,  32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);

    // Flush ten cycles into a divide, then restart right away.
    idle_check();
    launch(OP_DIVU, 32'd100, 32'd7);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_div_stall", 32'(stall_req), 32'd1);
    check("flush_div_done", 32'(done), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("after_flush_done", 32'(done), 32'd0);
    check("after_flush_stall", 32'(stall_req), 32'd0);
    check("after_flush_hi", hi_o, exp_hi);
    check("after_flush_lo", lo_o, exp_lo);
    launch(OP_DIVU, 32'd100, 32'd7);
    wait_result(34, 32'd2, 32'd14, 1'b0);

    // Flush while the multiply is in flight.
    idle_check();
    launch(OP_MULT, 32'd5, 32'd5);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b1;
    #1 check("flush_mul_stall", 32'(stall_req), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_mul_done", 32'(done), 32'd0);
    check("flush_mul_stall_off", 32'(stall_req), 32'd0);
    check("flush_mul_hi", hi_o, exp_hi);
    check("flush_mul_lo", lo_o, exp_lo);

    // Flush in the done cycle does not cancel the completed result.
    launch(OP_MULT, 32'd3, 32'd5);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("fin_flush_done", 32'(done), 32'd1);
    check("fin_flush_hi", hi_o, 32'd0);
    check("fin_flush_lo", lo_o, 32'd15);
    exp_hi = 32'd0;
    exp_lo = 32'd15;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("fin_flush_after_done", 32'(done), 32'd0);
    check("fin_flush_after_lo", lo_o, 32'd15);

    // Start together with flush in IDLE is not accepted.
    @(negedge clk);
    op    = OP_MULT;
    src1  = 32'd9;
    src2  = 32'd9;
    start = 1'b1;
    flush = 1'b1;
    #1 check("flush_start_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    #1;
    check("flush_start_idle", 32'(stall_req), 32'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 if (done) saw_done = 1'b1;
    end
    check("flush_start_no_done", 32'(saw_done), 32'd0);
    check("flush_start_lo", lo_o, 32'd15);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    launch(OP_DIVU, 32'd100, 32'd7);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("arst_hi", hi_o, 32'h0);
    check("arst_lo", lo_o, 32'h0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_dz", 32'(div_zero), 32'd0);
    check("arst_stall", 32'(stall_req), 32'd0);
    exp_hi = 32'h0;
    exp_lo = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1 if (done) saw_done = 1'b1;
    end
    check("arst_no_done", 32'(saw_done), 32'd0);

    do_op(OP_MULTU, 32'd6, 32'd7, 2, 32'd0, 32'd42, 1'b0);
    idle_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
